// File: rtl/lock_ctrl_pkg.sv
// lock_ctrl_pkg: state codes and default timing for the lock entry controller.
package lock_ctrl_pkg;
    localparam int ST_W = 2;
    typedef enum logic [ST_W-1:0] {
        ST_ENTRY    = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } lock_state_e;
    localparam int DEF_PIN_DIGITS     = 4;
    localparam int DEF_MAX_ATTEMPTS   = 3;
    localparam int DEF_UNLOCK_CYCLES  = 50;
    localparam int DEF_LOCKOUT_CYCLES = 200;
    localparam int DEF_CNT_W          = 8;
endpackage

// File: rtl/lock_entry_controller_hold_timer.sv
// hold_timer: loadable down-counter that saturates at zero, shared by unlock and lockout holds.
module hold_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/lock_entry_controller.sv
// lock_entry_controller: counts PIN digits, samples the comparator, and grants timed unlock or lockout.
module lock_entry_controller
    import lock_ctrl_pkg::*;
#(
    parameter int PIN_DIGITS     = DEF_PIN_DIGITS,
    parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
    parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              key_press,
    input  logic                              pin_match,
    input  logic                              cancel,
    output logic                              compare_sel,
    output logic                              entry_clr,
    output logic                              unlock,
    output logic                              lockout,
    output logic                              alarm,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] fail_count,
    output logic [ST_W-1:0]                   state
);
    localparam int FW = $clog2(MAX_ATTEMPTS + 1);
    localparam int DW = (PIN_DIGITS > 1) ? $clog2(PIN_DIGITS) : 1;

    lock_state_e   state_q;
    logic [DW-1:0] digit_cnt_q;
    logic [FW-1:0] fail_q;
    logic          entry_clr_q, alarm_q;
    logic          last_fail, tmr_load, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    assign last_fail = (fail_q == FW'(MAX_ATTEMPTS - 1));
    // Only load on transitions that actually use the timer.
    assign tmr_load  = (state_q == ST_CHECK) && (pin_match || last_fail);
    assign tmr_val   = pin_match ? CNT_W'(UNLOCK_CYCLES - 1) : CNT_W'(LOCKOUT_CYCLES - 1);

    hold_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (state_q == ST_UNLOCKED || state_q == ST_LOCKOUT),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ENTRY;
            digit_cnt_q <= '0;
            fail_q      <= '0;
            entry_clr_q <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            entry_clr_q <= 1'b0;
            alarm_q     <= 1'b0;
            case (state_q)
                ST_ENTRY: begin
                    if (cancel) begin
                        digit_cnt_q <= '0;
                        entry_clr_q <= 1'b1;
                    end else if (key_press) begin
                        if (digit_cnt_q == DW'(PIN_DIGITS - 1)) begin
                            digit_cnt_q <= '0;
                            state_q     <= ST_CHECK;
                        end else begin
                            digit_cnt_q <= digit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (pin_match) begin
                        state_q <= ST_UNLOCKED;
                        fail_q  <= '0;
                    end else if (last_fail) begin
                        state_q <= ST_LOCKOUT;
                        fail_q  <= FW'(MAX_ATTEMPTS);
                        alarm_q <= 1'b1;
                    end else begin
                        state_q     <= ST_ENTRY;
                        fail_q      <= fail_q + 1'b1;
                        entry_clr_q <= 1'b1;
                    end
                end
                ST_UNLOCKED: begin
                    if (cancel || tmr_zero) begin
                        state_q     <= ST_ENTRY;
                        entry_clr_q <= 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (tmr_zero) begin
                        state_q     <= ST_ENTRY;
                        fail_q      <= '0;
                        entry_clr_q <= 1'b1;
                    end
                end
                default: state_q <= ST_ENTRY;
            endcase
        end
    end

    assign compare_sel = (state_q == ST_CHECK);
    assign unlock      = (state_q == ST_UNLOCKED);
    assign lockout     = (state_q == ST_LOCKOUT);
    assign entry_clr   = entry_clr_q;
    assign alarm       = alarm_q;
    assign fail_count  = fail_q;
    assign state       = state_q;
endmodule

// File: tb/tb_lock_entry_controller.sv
// tb_lock_entry_controller: directed and random stimulus checked against a remaining-cycles model.
module tb_lock_entry_controller;
    localparam int N = 4, MA = 3, UC = 4, LC = 8, CW = 8;
    localparam int FW = $clog2(MA + 1);

    logic clk = 1'b0, reset = 1'b1, key_press = 1'b0, pin_match = 1'b0, cancel = 1'b0;
    logic compare_sel, entry_clr, unlock, lockout, alarm;
    logic [FW-1:0] fail_count;
    logic [1:0] state;

    lock_entry_controller #(
        .PIN_DIGITS(N), .MAX_ATTEMPTS(MA), .UNLOCK_CYCLES(UC), .LOCKOUT_CYCLES(LC), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .key_press(key_press), .pin_match(pin_match), .cancel(cancel),
        .compare_sel(compare_sel), .entry_clr(entry_clr), .unlock(unlock), .lockout(lockout),
        .alarm(alarm), .fail_count(fail_count), .state(state)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    // Model: digits typed, failures, pending check, and cycles of unlock/lockout still to show.
    int m_keys = 0, m_fails = 0, m_unl = 0, m_lck = 0;
    bit m_check = 0, m_clr = 0, m_alarm = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit nclr = 0, nal = 0;
        if (reset) begin
            m_keys = 0; m_fails = 0; m_unl = 0; m_lck = 0; m_check = 0;
        end else if (m_check) begin
            m_check = 0;
            if (pin_match) begin m_fails = 0; m_unl = UC; end
            else if (m_fails + 1 == MA) begin m_fails = MA; m_lck = LC; nal = 1; end
            else begin m_fails++; nclr = 1; end
        end else if (m_unl > 0) begin
            if (cancel) begin m_unl = 0; nclr = 1; end
            else begin m_unl--; if (m_unl == 0) nclr = 1; end
        end else if (m_lck > 0) begin
            m_lck--;
            if (m_lck == 0) begin m_fails = 0; nclr = 1; end
        end else if (cancel) begin
            m_keys = 0; nclr = 1;
        end else if (key_press) begin
            m_keys++;
            if (m_keys == N) begin m_keys = 0; m_check = 1; end
        end
        m_clr = nclr;
        m_alarm = nal;
    endtask

    task automatic check_all();
        int es;
        es = m_check ? 1 : (m_unl > 0) ? 2 : (m_lck > 0) ? 3 : 0;
        chk("state", 8'(state), 8'(es));
        chk("compare_sel", 8'(compare_sel), 8'(m_check));
        chk("unlock", 8'(unlock), 8'(m_unl > 0));
        chk("lockout", 8'(lockout), 8'(m_lck > 0));
        chk("entry_clr", 8'(entry_clr), 8'(m_clr));
        chk("alarm", 8'(alarm), 8'(m_alarm));
        chk("fail_count", 8'(fail_count), 8'(m_fails));
    endtask

    task automatic step(input bit k, input bit m, input bit c, input bit r);
        key_press = k; pin_match = m; cancel = c; reset = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic enter(input bit ok);
        repeat (N) step(1, 0, 0, 0);
        step(0, ok, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        enter(1); idle(6);
        enter(0); idle(2); enter(0); idle(2); enter(1); idle(6);
        enter(0); idle(1); enter(0); idle(1); enter(0);
        step(1, 0, 1, 0); step(1, 0, 0, 0); step(0, 0, 1, 0); idle(8);
        step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 1, 0); enter(1); idle(5);
        enter(0); idle(1);
        enter(1); step(0, 0, 0, 0); step(0, 0, 1, 0); idle(2);
        enter(0); idle(1); enter(0); idle(1);
        enter(0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 0, 1); idle(3);
        enter(0); enter(1); step(0, 0, 0, 1); idle(2);
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 499) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lock_entry_controller.md
Name: lock_entry_controller

Overview:
Sequencing and policy stage directly downstream of the digital lock datapath (encoder, PIN shift register, select mux, comparator). It counts digit key presses and drives the compare select once a full PIN is entered. It samples the comparator's match result, then grants a timed unlock or counts a failure. After MAX_ATTEMPTS consecutive failures it enters a timed lockout and raises an alarm pulse.

Parameters:
PIN_DIGITS, 4, digits per PIN entry (>=1).
MAX_ATTEMPTS, 3, consecutive failures that trigger lockout (>=1).
UNLOCK_CYCLES, 50, clock cycles unlock is held (>=1, < 2^CNT_W).
LOCKOUT_CYCLES, 200, clock cycles lockout is held (>=1, < 2^CNT_W).
CNT_W, 8, width of the shared hold timer.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
key_press  in  1  one-cycle strobe, one digit accepted by the PIN shift register this cycle.
pin_match  in  1  comparator output, entered PIN equals stored PIN.
cancel  in  1  user abort / relock request.
compare_sel  out  1  drives the datapath mux select, high only in CHECK.
entry_clr  out  1  one-cycle pulse clearing the PIN shift register.
unlock  out  1  high while in UNLOCKED.
lockout  out  1  high while in LOCKOUT.
alarm  out  1  one-cycle pulse on entry to LOCKOUT.
fail_count  out  $clog2(MAX_ATTEMPTS+1)  consecutive failures so far.
state  out  2  current state code, for debug.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: state=ENTRY, digit_cnt=0, timer=0, fail_count=0, and every output is 0.
- Reset asserted in any state, including mid-LOCKOUT or mid-UNLOCKED, returns all of the above to reset values on the next edge.
- States and codes: ENTRY=0, CHECK=1, UNLOCKED=2, LOCKOUT=3.
- compare_sel, unlock and lockout are decoded directly from the state register (Moore); no combinational path from any input.
- entry_clr and alarm are registered pulses, exactly 1 cycle wide.
- ENTRY:
  - key_press increments digit_cnt.
  - key_press with digit_cnt==PIN_DIGITS-1 clears digit_cnt and moves to CHECK on that edge.
  - cancel clears digit_cnt and pulses entry_clr the next cycle. No attempt is counted. cancel beats a simultaneous key_press.
- CHECK:
  - Lasts exactly 1 cycle. compare_sel=1 and pin_match is sampled at the end of the cycle.
  - key_press and cancel are ignored.
  - If pin_match=1: go to UNLOCKED, fail_count<=0, timer<=UNLOCK_CYCLES-1.
  - Else if fail_count+1==MAX_ATTEMPTS: go to LOCKOUT, fail_count<=MAX_ATTEMPTS, timer<=LOCKOUT_CYCLES-1, alarm pulses the next cycle.
  - Else: go to ENTRY, fail_count<=fail_count+1, entry_clr pulses the next cycle.
- UNLOCKED:
  - timer decrements each cycle. At timer==0, go to ENTRY and pulse entry_clr.
  - unlock is high for exactly UNLOCK_CYCLES cycles.
  - cancel forces ENTRY plus entry_clr on the next edge, with priority over timer expiry.
  - key_press is ignored.
- LOCKOUT:
  - timer decrements each cycle. At timer==0, go to ENTRY, fail_count<=0, and pulse entry_clr.
  - lockout is high for exactly LOCKOUT_CYCLES cycles.
  - key_press and cancel are ignored.
- Latency: the last key_press edge is followed by 1 CHECK cycle, and unlock or lockout rises on the edge ending CHECK. Key-to-unlock latency is therefore 2 edges.
- Widths: timer never wraps; decrement is gated at 0. fail_count never exceeds MAX_ATTEMPTS.

Decomposition:
- lock_ctrl_pkg holds:
  - state codes ST_ENTRY, ST_CHECK, ST_UNLOCKED, ST_LOCKOUT;
  - the state width;
  - default timing constants.
- One sub-module, hold_timer: loadable down-counter with load value, enable and zero flag, CNT_W wide. It is shared by the UNLOCKED and LOCKOUT states.

Test Plan:
Use PIN_DIGITS=4, MAX_ATTEMPTS=3, UNLOCK_CYCLES=4, LOCKOUT_CYCLES=8.
- Correct entry: 4 key_press strobes, pin_match=1 during CHECK -> compare_sel high for 1 cycle; unlock high for exactly 4 cycles; then state=0, entry_clr 1-cycle pulse, fail_count=0.
- Two wrong entries then a correct one: pin_match=0, 0, 1 -> fail_count goes 1, then 2, then 0 on unlock; entry_clr pulses after each failure; lockout stays 0.
- Three wrong entries: -> alarm pulses once; lockout high for exactly 8 cycles; key_press and cancel during lockout have no effect; exit gives fail_count=0 and an entry_clr pulse.
- cancel after 2 digits, then 4 digits with a match -> digit_cnt restarts; CHECK occurs only after the 4 new strobes; fail_count is unchanged by the cancel.
- cancel on cycle 2 of UNLOCKED -> unlock drops the next cycle, state=ENTRY, entry_clr pulses.
- reset asserted on cycle 3 of LOCKOUT -> next edge gives state=0, lockout=0, fail_count=0, all outputs 0.
